time_dmr_retry_end: RTL and testbench
=====================================

Name: time_dmr_retry_end

Overview:
- Receiving end of the time-redundant DMR stream: every item arrives twice, back-to-back, tagged with the same ID.
- Compares the two copies. If they agree, emits one item downstream. If they disagree or a copy is lost, discards the pair and issues a retry request for that ID back to the upstream replicator.
- Sits after the redundant section (e.g. a DMR'd pipeline stage), mirroring the TMR end-voter in the same library.

Parameters:
- DataType, logic [7:0], payload type.
- IDSize, 4, width of the item ID tag.
- LockTimeout, 4, cycles to wait for the second copy before dropping the first copy.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  1 = redundancy checking; 0 = pass-through
- data_i  in  $bits(DataType)  upstream data copy
- id_i  in  IDSize  upstream item ID
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  $bits(DataType)  checked data
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- retry_id_o  out  IDSize  ID to be re-sent
- retry_valid_o  out  1  retry request valid
- retry_ready_i  in  1  upstream accepts retry
- fault_detected_o  out  1  one-cycle pulse on any detected fault

Behaviour:
- Reset values: valid_o=0, data_o=0, retry_valid_o=0, retry_id_o=0, fault_detected_o=0. State is EMPTY; last-output-ID flag is invalid.
- enable_i=0: combinational pass-through (data_o=data_i, valid_o=valid_i, ready_o=ready_i). Retry outputs and fault_detected_o stay 0. Internal state is held in EMPTY.
- enable_i toggling mid-pair: the partial pair is discarded without flagging a fault.
- Input handshake fires when valid_i && ready_o. Output handshake fires when valid_o && ready_i.
- Retry interface: retry_valid_o/retry_id_o are stable until retry_ready_i. While a retry is pending, ready_o=0.
- States:
  - EMPTY: ready_o=1 (unless a retry is pending).
    - Accept copy → store data/ID, go to HAVE_ONE, start timeout counter at 0.
    - If id_i equals the last-output ID (flag valid), drop the copy silently (stale duplicate), no fault.
  - HAVE_ONE: ready_o=1. Counter increments each cycle without a handshake.
    - Accept copy with same ID and equal data → register to data_o, valid_o=1, record last-output ID, go to OUTPUT.
    - Same ID, data differs → fault pulse, retry_valid_o=1 with that ID, go to EMPTY.
    - Different ID → fault pulse; drop the stored copy, store the new copy, restart the counter, stay in HAVE_ONE. No retry is issued (the lost item is the upstream's responsibility via its own timeout).
    - Counter reaches LockTimeout → fault pulse, retry for the stored ID, go to EMPTY.
  - OUTPUT: valid_o=1; data_o held stable until the output handshake.
    - ready_o = ready_i: a first copy may be accepted in the same cycle as the output handshake, going directly to HAVE_ONE. The stale-ID rule applies.
    - Handshake with no input → EMPTY.
- Output latency: valid_o rises the cycle after the second matching copy is accepted.
- Throughput: one output per two input cycles.
- Counter width: $clog2(LockTimeout+1). The counter saturates and does not wrap.
- ID compare uses full IDSize; ID wrap-around is legal (0 follows 2^IDSize-1).
- Simultaneous new retry while one is pending cannot occur, because ready_o=0 while pending. Timeout does not advance while a retry is pending.
- Asynchronous reset mid-operation aborts everything immediately to reset values.

Decomposition:
- Shared redundancy package: the state enum (EMPTY, HAVE_ONE, OUTPUT) and an ID typedef parameterised by IDSize.
- No sub-module. The single natural split is the retry request register; it stays inline.

Test Plan:
- enable_i=0, inputs 0x11,0x22 with ready_i=1 → data_o follows combinationally, valid_o=valid_i, no fault or retry.
- enable_i=1, inputs (0xA5,id3),(0xA5,id3) → valid_o=1 one cycle after the second copy with 0xA5; no fault.
- (0x3C,id5),(0x3D,id5) → fault pulse; retry_valid_o=1, retry_id_o=5 held until retry_ready_i; ready_o=0 meanwhile; no output.
- (0x77,id6) then idle for LockTimeout=4 cycles → fault pulse, retry_id_o=6; next pair (0x77,id6)x2 → output 0x77.
- Output 0x10 id1 with ready_i=0 for 5 cycles → data_o/valid_o stable. A stray third (0x10,id1) is then dropped silently with no second output.
- Reset asserted while in HAVE_ONE → all outputs 0 immediately; the subsequent clean pair (0x55,id0)x2 → output 0x55.

Source files
------------

// File: rtl/time_dmr_retry_end_pkg.sv
// Shared types for the time-redundant DMR receiving end: pair-tracking state,
// the default ID tag type and the lock-timeout counter sizing.
package time_dmr_retry_end_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_HAVE_ONE = 2'd1,
    ST_OUTPUT   = 2'd2
  } retry_state_e;

  localparam int unsigned DefaultIdSize = 4;
  typedef logic [DefaultIdSize-1:0] dmr_id_t;

  // Counter must be able to hold the timeout value itself.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/time_dmr_retry_end.sv
// Receiving end of a time-redundant DMR stream: compares the two back-to-back
// copies of each item, forwards agreeing pairs and requests a resend otherwise.
module time_dmr_retry_end
  import time_dmr_retry_end_pkg::*;
#(
  parameter type         DataType    = logic [7:0],
  parameter int unsigned IDSize      = 4,
  parameter int unsigned LockTimeout = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IDSize-1:0] retry_id_o,
  output logic              retry_valid_o,
  input  logic              retry_ready_i,
  output logic              fault_detected_o,
  output retry_state_e      dbg_state_o
);

  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both high; valid never waits on ready, and a raised retry
  // request (retry_valid_o/retry_id_o) holds steady until retry_ready_i.

  localparam int unsigned CntW = cnt_width(LockTimeout);
  typedef logic [IDSize-1:0] id_t;
  typedef logic [CntW-1:0]   cnt_t;
  localparam cnt_t CntMax = cnt_t'(LockTimeout);

  retry_state_e r_state;
  DataType      r_data;
  id_t          r_id;
  cnt_t         r_cnt;
  id_t          r_last_id;
  logic         r_last_valid;
  DataType      r_data_o;
  logic         r_valid_o;
  logic         r_retry_valid;
  id_t          r_retry_id;
  logic         r_fault;

  logic w_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_stale;
  logic w_same_id;
  logic w_same_data;

  // Upstream is stalled while a retry is outstanding so it can service it.
  always_comb begin
    w_ready = 1'b0;
    if (!r_retry_valid) begin
      case (r_state)
        ST_EMPTY:    w_ready = 1'b1;
        ST_HAVE_ONE: w_ready = 1'b1;
        ST_OUTPUT:   w_ready = ready_i;
        default:     w_ready = 1'b0;
      endcase
    end
  end

  assign w_in_fire   = valid_i & w_ready;
  assign w_out_fire  = r_valid_o & ready_i;
  assign w_stale     = r_last_valid & (id_i == r_last_id);
  assign w_same_id   = (id_i == r_id);
  assign w_same_data = (data_i == r_data);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_EMPTY;
      r_data        <= '0;
      r_id          <= '0;
      r_cnt         <= '0;
      r_last_id     <= '0;
      r_last_valid  <= 1'b0;
      r_data_o      <= '0;
      r_valid_o     <= 1'b0;
      r_retry_valid <= 1'b0;
      r_retry_id    <= '0;
      r_fault       <= 1'b0;
    end else if (!enable_i) begin
      // Pass-through mode: any partial pair is dropped without a fault.
      r_state       <= ST_EMPTY;
      r_cnt         <= '0;
      r_last_valid  <= 1'b0;
      r_valid_o     <= 1'b0;
      r_retry_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      if (r_retry_valid && retry_ready_i) begin
        r_retry_valid <= 1'b0;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire && !w_stale) begin
            r_data  <= data_i;
            r_id    <= id_i;
            r_cnt   <= '0;
            r_state <= ST_HAVE_ONE;
          end
        end
        ST_HAVE_ONE: begin
          if (w_in_fire) begin
            if (w_same_id && w_same_data) begin
              r_data_o     <= data_i;
              r_valid_o    <= 1'b1;
              r_last_id    <= id_i;
              r_last_valid <= 1'b1;
              r_state      <= ST_OUTPUT;
            end else if (w_same_id) begin
              r_fault       <= 1'b1;
              r_retry_valid <= 1'b1;
              r_retry_id    <= id_i;
              r_state       <= ST_EMPTY;
            end else begin
              // Partner copy was lost; upstream's own timeout covers it.
              r_fault <= 1'b1;
              r_data  <= data_i;
              r_id    <= id_i;
              r_cnt   <= '0;
            end
          end else if (!r_retry_valid) begin
            if (r_cnt == CntMax) begin
              r_fault       <= 1'b1;
              r_retry_valid <= 1'b1;
              r_retry_id    <= r_id;
              r_state       <= ST_EMPTY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (w_out_fire) begin
            r_valid_o <= 1'b0;
            if (w_in_fire && !w_stale) begin
              r_data  <= data_i;
              r_id    <= id_i;
              r_cnt   <= '0;
              r_state <= ST_HAVE_ONE;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign ready_o          = enable_i ? w_ready : ready_i;
  assign data_o           = enable_i ? r_data_o : data_i;
  assign valid_o          = enable_i ? r_valid_o : valid_i;
  assign retry_valid_o    = enable_i & r_retry_valid;
  assign retry_id_o       = enable_i ? r_retry_id : '0;
  assign fault_detected_o = enable_i & r_fault;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_time_dmr_retry_end.sv
// Bench for time_dmr_retry_end: scenario tasks with inline checks, plus a
// scoreboard that pops expected outputs/retries when the DUT hands them over.
module tb_time_dmr_retry_end;
  import time_dmr_retry_end_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         enable_i;
  logic [7:0]   data_i;
  logic [3:0]   id_i;
  logic         valid_i;
  logic         ready_o;
  logic [7:0]   data_o;
  logic         valid_o;
  logic         ready_i;
  logic [3:0]   retry_id_o;
  logic         retry_valid_o;
  logic         retry_ready_i;
  logic         fault_detected_o;
  retry_state_e dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_retry_q[$];

  time_dmr_retry_end #(
    .DataType(logic [7:0]), .IDSize(4), .LockTimeout(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .data_i(data_i), .id_i(id_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .retry_id_o(retry_id_o), .retry_valid_o(retry_valid_o),
    .retry_ready_i(retry_ready_i), .fault_detected_o(fault_detected_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  // scoreboard: sampled on the falling edge, handshakes complete on the next rise
  always @(negedge clk_i) begin
    if (rst_ni && enable_i && valid_o && ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got data_o=%h, none expected", data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_err++;
          $display("FAIL output_data: got %h, expected %h", data_o, e);
        end
      end
    end
    if (rst_ni && enable_i && retry_valid_o && retry_ready_i) begin
      n_vec++;
      if (exp_retry_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_retry: got retry_id_o=%0d, none expected", retry_id_o);
      end else begin
        logic [3:0] r;
        r = exp_retry_q.pop_front();
        if (retry_id_o !== r) begin
          n_err++;
          $display("FAIL retry_id: got %0d, expected %0d", retry_id_o, r);
        end
      end
    end
  end

  // drivers
  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] id);
    int t;
    t = 0;
    data_i = d; id_i = id; valid_i = 1'b1;
    @(negedge clk_i);
    while (!ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: ready_o=%b for id %0d, expected 1", ready_o, id);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst_ni = 1'b0; enable_i = 1'b1; data_i = '0; id_i = '0; valid_i = 1'b0;
    ready_i = 1'b1; retry_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++;
    if ({valid_o, data_o, retry_valid_o, retry_id_o, fault_detected_o} !== 15'd0 ||
        dbg_state_o !== ST_EMPTY) begin
      n_err++;
      $display("FAIL reset_values: got v=%b d=%h rv=%b rid=%0d f=%b st=%0d, expected all 0",
               valid_o, data_o, retry_valid_o, retry_id_o, fault_detected_o, dbg_state_o);
    end
    rst_ni = 1'b1;
    idle(1);
  endtask

  task automatic test_passthrough();
    enable_i = 1'b0; ready_i = 1'b1;
    valid_i = 1'b1; data_i = 8'h11; id_i = 4'd2;
    #1;
    n_vec++;
    if (data_o !== 8'h11 || valid_o !== 1'b1 || ready_o !== 1'b1 ||
        retry_valid_o !== 1'b0 || fault_detected_o !== 1'b0) begin
      n_err++;
      $display("FAIL passthrough_11: got d=%h v=%b r=%b rv=%b f=%b, expected 11 1 1 0 0",
               data_o, valid_o, ready_o, retry_valid_o, fault_detected_o);
    end
    idle(1);
    data_i = 8'h22; ready_i = 1'b0;
    #1;
    n_vec++;
    if (data_o !== 8'h22 || valid_o !== 1'b1 || ready_o !== 1'b0 || fault_detected_o !== 1'b0) begin
      n_err++;
      $display("FAIL passthrough_22: got d=%h v=%b r=%b f=%b, expected 22 1 0 0",
               data_o, valid_o, ready_o, fault_detected_o);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    #1;
    n_vec++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL passthrough_idle: got v=%b r=%b, expected 0 1", valid_o, ready_o);
    end
    idle(1);
    enable_i = 1'b1;
    idle(1);
  endtask

  task automatic test_match();
    ready_i = 1'b1;
    send(8'hA5, 4'd3);
    n_vec++;
    if (valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL match_early_valid: got valid_o=%b, expected 0", valid_o);
    end
    exp_q.push_back(8'hA5);
    send(8'hA5, 4'd3);
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== 8'hA5 || fault_detected_o !== 1'b0) begin
      n_err++;
      $display("FAIL match_output: got v=%b d=%h f=%b, expected 1 a5 0",
               valid_o, data_o, fault_detected_o);
    end
    idle(2);
  endtask

  task automatic test_mismatch_retry();
    retry_ready_i = 1'b0;
    send(8'h3C, 4'd5);
    send(8'h3D, 4'd5);
    n_vec++;
    if (fault_detected_o !== 1'b1 || retry_valid_o !== 1'b1 || retry_id_o !== 4'd5 ||
        ready_o !== 1'b0 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL mismatch_detect: got f=%b rv=%b rid=%0d r=%b v=%b, expected 1 1 5 0 0",
               fault_detected_o, retry_valid_o, retry_id_o, ready_o, valid_o);
    end
    valid_i = 1'b1; data_i = 8'h3C; id_i = 4'd5;
    idle(3);
    n_vec++;
    if (fault_detected_o !== 1'b0 || retry_valid_o !== 1'b1 || retry_id_o !== 4'd5 ||
        ready_o !== 1'b0 || valid_o !== 1'b0 || dbg_state_o !== ST_EMPTY) begin
      n_err++;
      $display("FAIL mismatch_hold: got f=%b rv=%b rid=%0d r=%b v=%b st=%0d, expected 0 1 5 0 0 0",
               fault_detected_o, retry_valid_o, retry_id_o, ready_o, valid_o, dbg_state_o);
    end
    valid_i = 1'b0;
    exp_retry_q.push_back(4'd5);
    retry_ready_i = 1'b1;
    idle(1);
    retry_ready_i = 1'b0;
    n_vec++;
    if (retry_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL mismatch_release: got rv=%b r=%b, expected 0 1", retry_valid_o, ready_o);
    end
  endtask

  task automatic test_timeout();
    logic found;
    send(8'h77, 4'd6);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      n_vec++;
      if (retry_valid_o !== 1'b0 || fault_detected_o !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_early: idle %0d got rv=%b f=%b, expected 0 0",
                 k, retry_valid_o, fault_detected_o);
      end
    end
    found = 1'b0;
    for (int k = 0; k < 3 && !found; k++) begin
      idle(1);
      if (retry_valid_o) found = 1'b1;
    end
    n_vec++;
    if (found !== 1'b1 || fault_detected_o !== 1'b1 || retry_id_o !== 4'd6) begin
      n_err++;
      $display("FAIL timeout_retry: got seen=%b f=%b rid=%0d, expected 1 1 6",
               found, fault_detected_o, retry_id_o);
    end
    exp_retry_q.push_back(4'd6);
    retry_ready_i = 1'b1;
    idle(1);
    retry_ready_i = 1'b0;
    exp_q.push_back(8'h77);
    send(8'h77, 4'd6);
    send(8'h77, 4'd6);
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== 8'h77) begin
      n_err++;
      $display("FAIL timeout_resend: got v=%b d=%h, expected 1 77", valid_o, data_o);
    end
    idle(2);
  endtask

  task automatic test_output_hold_stale();
    ready_i = 1'b0;
    exp_q.push_back(8'h10);
    send(8'h10, 4'd1);
    send(8'h10, 4'd1);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (valid_o !== 1'b1 || data_o !== 8'h10 || ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL hold_stable: cycle %0d got v=%b d=%h r=%b, expected 1 10 0",
                 k, valid_o, data_o, ready_o);
      end
      idle(1);
    end
    ready_i = 1'b1;
    send(8'h10, 4'd1);
    idle(7);
    n_vec++;
    if (valid_o !== 1'b0 || retry_valid_o !== 1'b0 || dbg_state_o !== ST_EMPTY) begin
      n_err++;
      $display("FAIL stale_drop: got v=%b rv=%b st=%0d, expected 0 0 0",
               valid_o, retry_valid_o, dbg_state_o);
    end
  endtask

  task automatic test_id_change();
    send(8'h40, 4'd7);
    send(8'h41, 4'd8);
    n_vec++;
    if (fault_detected_o !== 1'b1 || retry_valid_o !== 1'b0 || dbg_state_o !== ST_HAVE_ONE) begin
      n_err++;
      $display("FAIL id_change: got f=%b rv=%b st=%0d, expected 1 0 1",
               fault_detected_o, retry_valid_o, dbg_state_o);
    end
    exp_q.push_back(8'h41);
    send(8'h41, 4'd8);
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== 8'h41 || fault_detected_o !== 1'b0) begin
      n_err++;
      $display("FAIL id_change_recover: got v=%b d=%h f=%b, expected 1 41 0",
               valid_o, data_o, fault_detected_o);
    end
    idle(2);
  endtask

  task automatic test_enable_toggle();
    send(8'h12, 4'd9);
    enable_i = 1'b0;
    idle(1);
    enable_i = 1'b1;
    #1;
    n_vec++;
    if (dbg_state_o !== ST_EMPTY || fault_detected_o !== 1'b0 || retry_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL toggle_discard: got st=%0d f=%b rv=%b, expected 0 0 0",
               dbg_state_o, fault_detected_o, retry_valid_o);
    end
    idle(1);
    send(8'h12, 4'd9);
    n_vec++;
    if (valid_o !== 1'b0 || dbg_state_o !== ST_HAVE_ONE) begin
      n_err++;
      $display("FAIL toggle_first: got v=%b st=%0d, expected 0 1", valid_o, dbg_state_o);
    end
    exp_q.push_back(8'h12);
    send(8'h12, 4'd9);
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== 8'h12) begin
      n_err++;
      $display("FAIL toggle_pair: got v=%b d=%h, expected 1 12", valid_o, data_o);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [7:0] d;
    logic [3:0] id;
    ready_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      id = 4'((10 + i) % 16);
      exp_q.push_back(d);
      send(d, id);
      send(d, id);
    end
    n_vec++;
    if (cyc - c0 !== 16) begin
      n_err++;
      $display("FAIL b2b_throughput: got %0d cycles, expected 16", cyc - c0);
    end
    idle(2);
    n_vec++;
    if (exp_q.size() !== 0 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got pending=%0d v=%b, expected 0 0", exp_q.size(), valid_o);
    end
  endtask

  task automatic test_reset_mid_pair();
    send(8'h99, 4'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({valid_o, data_o, retry_valid_o, retry_id_o, fault_detected_o} !== 15'd0 ||
        dbg_state_o !== ST_EMPTY) begin
      n_err++;
      $display("FAIL reset_mid_pair: got v=%b d=%h rv=%b rid=%0d f=%b st=%0d, expected all 0",
               valid_o, data_o, retry_valid_o, retry_id_o, fault_detected_o, dbg_state_o);
    end
    #1;
    rst_ni = 1'b1;
    idle(1);
    exp_q.push_back(8'h55);
    send(8'h55, 4'd0);
    send(8'h55, 4'd0);
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== 8'h55) begin
      n_err++;
      $display("FAIL reset_recover: got v=%b d=%h, expected 1 55", valid_o, data_o);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_match();
    test_mismatch_retry();
    test_timeout();
    test_output_hold_stale();
    test_id_change();
    test_enable_toggle();
    test_back_to_back();
    test_reset_mid_pair();
    n_vec++;
    if (exp_q.size() !== 0 || exp_retry_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d outputs and %0d retries pending, expected 0 0",
               exp_q.size(), exp_retry_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
